// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: uop encodings and classification helpers shared by the load/store unit,
// the dcache and the decoder.
package lsu_ctrl_pkg;
    typedef logic [3:0] uop_t;

    localparam uop_t NOP_UOP = 4'b0000;
    localparam uop_t STR_UOP = 4'b1001;
    localparam uop_t LDR_UOP = 4'b1010;
    localparam uop_t LDM_UOP = 4'b1011;
    localparam uop_t STM_UOP = 4'b1100;

    function automatic logic is_mem_uop(input uop_t u);
        return u inside {STR_UOP, LDR_UOP, LDM_UOP, STM_UOP};
    endfunction

    function automatic logic is_load_uop(input uop_t u);
        return u == LDR_UOP || u == LDM_UOP;
    endfunction

    function automatic logic is_multi_uop(input uop_t u);
        return u == LDM_UOP || u == STM_UOP;
    endfunction
endpackage

// File: rtl/lsu_ctrl_reglist_scan.sv
// reglist_scan: lowest set register index, non-empty flag and popcount of an LDM/STM list.
module reglist_scan (
    input  logic [15:0] list,
    output logic [3:0]  low_idx,
    output logic        valid,
    output logic [4:0]  count
);
    always_comb begin
        low_idx = '0;
        count   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list[i]) low_idx = i[3:0];
            count = count + {4'b0, list[i]};
        end
    end

    assign valid = |list;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage; computes addresses, sequences dcache accesses
// and emits load and base-register writebacks.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_uop,
    input  logic [31:0]       in_base,
    input  logic [3:0]        in_rn,
    input  logic [31:0]       in_offset,
    input  logic              in_pre,
    input  logic              in_up,
    input  logic              in_wb,
    input  logic [3:0]        in_rd,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [15:0]       in_reglist,
    output logic [3:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_data,
    output logic [3:0]        dc_uop,
    input  logic [DATA_W-1:0] dc_rdata,
    output logic              wb_valid,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              base_wb_valid,
    output logic [3:0]        base_wb_rn,
    output logic [31:0]       base_wb_data,
    output logic              done
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state;
    uop_t              uop_q;
    logic [31:0]       ea_q;
    logic [31:0]       upd_q;
    logic [3:0]        rn_q;
    logic [3:0]        cur_q;
    logic              wb_q;
    logic [15:0]       list_q;
    logic [DATA_W-1:0] dat_q;

    logic [3:0]  in_low;
    logic        in_any;
    logic [4:0]  in_cnt;
    logic [3:0]  cur_low;
    logic        cur_any;
    logic [4:0]  cur_cnt;
    logic [15:0] rest;
    logic        multi_q;
    logic        load_q;

    logic [31:0] n4;
    logic [31:0] single_upd;
    logic [31:0] multi_upd;
    logic [31:0] acc_upd;
    logic [31:0] acc_ea;
    logic        in_multi;
    logic        conflict;
    logic        empty;
    logic        unused_ok;

    reglist_scan u_in_scan (
        .list    (in_reglist),
        .low_idx (in_low),
        .valid   (in_any),
        .count   (in_cnt)
    );

    reglist_scan u_cur_scan (
        .list    (list_q),
        .low_idx (cur_low),
        .valid   (cur_any),
        .count   (cur_cnt)
    );

    assign multi_q  = is_multi_uop(uop_q);
    assign load_q   = is_load_uop(uop_q);
    assign rest     = list_q & ~(16'd1 << cur_low);
    assign in_multi = is_multi_uop(in_uop);

    // Multiple transfers always walk upwards from the lowest address; DA/DB start below base.
    always_comb begin
        n4         = {25'd0, in_cnt, 2'b00};
        single_upd = in_up ? in_base + in_offset : in_base - in_offset;
        multi_upd  = in_up ? in_base + n4 : in_base - n4;
        acc_upd    = in_multi ? multi_upd : single_upd;
        acc_ea     = !in_multi ? (in_pre ? single_upd : in_base) :
                     in_up     ? (in_pre ? in_base + 32'd4 : in_base) :
                                 (in_pre ? multi_upd : multi_upd + 32'd4);
        conflict   = in_uop == LDR_UOP ? in_rd == in_rn :
                     in_uop == LDM_UOP ? in_reglist[in_rn] : 1'b0;
        empty      = in_multi && !in_any;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            uop_q    <= NOP_UOP;
            ea_q     <= '0;
            upd_q    <= '0;
            rn_q     <= '0;
            cur_q    <= '0;
            wb_q     <= 1'b0;
            list_q   <= '0;
            dat_q    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid && is_mem_uop(in_uop)) begin
                    uop_q  <= in_uop;
                    ea_q   <= acc_ea;
                    upd_q  <= acc_upd;
                    rn_q   <= in_rn;
                    cur_q  <= in_rd;
                    list_q <= in_multi ? in_reglist : 16'd0;
                    wb_q   <= in_wb && !conflict && !empty;
                    if (in_uop == STR_UOP) dat_q <= in_store_data;
                    state  <= empty ? DONE : ACCESS;
                end
                ACCESS: begin
                    if (multi_q) begin
                        cur_q  <= cur_low;
                        list_q <= rest;
                        if (rest != 16'd0) ea_q <= ea_q + 32'd4;
                    end
                    if (uop_q == STM_UOP) dat_q <= rf_rd_data;
                    state <= load_q ? CAPTURE : (multi_q && rest != 16'd0) ? ACCESS : DONE;
                end
                CAPTURE: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= cur_q;
                    wb_data  <= dc_rdata;
                    state    <= cur_any ? ACCESS : DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = state == IDLE;
    assign dc_uop        = state == ACCESS ? uop_q : NOP_UOP;
    assign dc_addr       = ea_q[ADDR_W+1:2];
    assign dc_data       = (state == ACCESS && uop_q == STM_UOP) ? rf_rd_data : dat_q;
    assign rf_rd_addr    = cur_low;
    assign done          = state == DONE;
    assign base_wb_valid = state == DONE && wb_q;
    assign base_wb_rn    = rn_q;
    assign base_wb_data  = upd_q;

    assign unused_ok = ^{ea_q[31:ADDR_W+2], ea_q[1:0], in_low, cur_cnt};
endmodule
